// File: rtl/bidir_transceiver.sv
// Registered bidirectional bus transceiver: forwards side A to side B (or B to A)
// through one capture register, with a guarded dead period on every reversal.
module bidir_transceiver #(
   parameter int WIDTH    = 8,
   parameter int TURN_CYC = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   inout  wire  [WIDTH-1:0] a,
   inout  wire  [WIDTH-1:0] b,
   output logic             cur_dir,
   output logic             active,
   output logic             turning,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_A2B  = 2'd1;
   localparam logic [1:0] S_B2A  = 2'd2;
   localparam logic [1:0] S_TURN = 2'd3;

   localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

   logic [1:0]       state;
   logic [TW-1:0]    turn_cnt;
   logic [WIDTH-1:0] data_q;
   logic             drive;

   // Outputs decode straight from registers so an async reset releases both buses at once.
   assign a        = (drive && state == S_B2A) ? data_q : {WIDTH{1'bz}};
   assign b        = (drive && state == S_A2B) ? data_q : {WIDTH{1'bz}};
   assign active   = drive;
   assign turning  = (state == S_TURN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         turn_cnt <= '0;
         data_q   <= '0;
         drive    <= 1'b0;
         cur_dir  <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         if (drive && xfer_cnt != {CNT_W{1'b1}})
            xfer_cnt <= xfer_cnt + CNT_W'(1);

         case (state)
            S_IDLE: begin
               drive    <= 1'b0;
               turn_cnt <= '0;
               if (en) begin
                  state   <= dir ? S_B2A : S_A2B;
                  cur_dir <= dir;
               end
            end
            S_A2B, S_B2A: begin
               if (!en) begin
                  state <= S_IDLE;
                  drive <= 1'b0;
               end else if (dir != (state == S_B2A)) begin
                  state    <= S_TURN;
                  drive    <= 1'b0;
                  turn_cnt <= '0;
               end else begin
                  drive  <= 1'b1;
                  data_q <= (state == S_A2B) ? a : b;
               end
            end
            S_TURN: begin
               // Exit direction is taken only on the final edge, so dir glitches mid-turn are ignored.
               if (!en) begin
                  state    <= S_IDLE;
                  turn_cnt <= '0;
               end else if (turn_cnt == TURN_LAST) begin
                  state    <= dir ? S_B2A : S_A2B;
                  cur_dir  <= dir;
                  turn_cnt <= '0;
               end else begin
                  turn_cnt <= turn_cnt + TW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               drive <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bidir_transceiver.sv
// Directed-then-random bench for bidir_transceiver, checked against a
// behavioural model of modes, ages and a saturating transfer count.
module tb_bidir_transceiver;

   localparam int W  = 8;
   localparam int TC = 2;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst, en, dir;
   logic [W-1:0] a_drv, b_drv;
   logic a_oe, b_oe;
   wire  [W-1:0] a_bus, b_bus;
   logic cur_dir, active, turning;
   logic [CW-1:0] xfer_cnt;

   assign a_bus = a_oe ? a_drv : {W{1'bz}};
   assign b_bus = b_oe ? b_drv : {W{1'bz}};

   always #5 clk = ~clk;

   bidir_transceiver #(.WIDTH(W), .TURN_CYC(TC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .a(a_bus), .b(b_bus),
      .cur_dir(cur_dir), .active(active), .turning(turning), .xfer_cnt(xfer_cnt)
   );

   int checks = 0;
   int failures = 0;

   // Model: mode 0 idle, 1 A->B, 2 B->A, 3 turn; age = edges since entering a transfer mode.
   int mode, age, tage, cnt;
   logic mdir;
   logic [W-1:0] exp_data;
   logic [W-1:0] zval;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_active();
      return (mode == 1 || mode == 2) && age >= 1;
   endfunction

   task automatic model_reset();
      mode = 0; age = 0; tage = 0; cnt = 0; mdir = 1'b0; exp_data = '0;
   endtask

   task automatic model_step(input bit e, input bit d);
      if (model_active()) cnt = (cnt + 1 > 7) ? 7 : cnt + 1;
      case (mode)
         0: if (e) begin mode = d ? 2 : 1; age = 0; mdir = d; end
         1, 2: begin
            if (!e) mode = 0;
            else if (d != (mode == 2)) begin mode = 3; tage = 0; end
            else begin age++; exp_data = (mode == 1) ? a_drv : b_drv; end
         end
         default: begin
            if (!e) mode = 0;
            else begin
               tage++;
               if (tage == TC) begin mode = d ? 2 : 1; age = 0; mdir = d; end
            end
         end
      endcase
   endtask

   task automatic set_drives(input bit use_v, input logic [W-1:0] v);
      a_oe  = (mode == 1);
      b_oe  = (mode == 2);
      a_drv = use_v ? v : W'($urandom);
      b_drv = use_v ? v : W'($urandom);
   endtask

   task automatic check_all();
      logic [W-1:0] ea, eb;
      ea = zval; eb = zval;
      if (mode == 1) begin ea = a_drv; if (model_active()) eb = exp_data; end
      if (mode == 2) begin eb = b_drv; if (model_active()) ea = exp_data; end
      chk("active",   32'(active),   32'(model_active()));
      chk("turning",  32'(turning),  32'(mode == 3));
      chk("cur_dir",  32'(cur_dir),  32'(mdir));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(cnt));
      chk("bus_a",    32'(a_bus),    32'(ea));
      chk("bus_b",    32'(b_bus),    32'(eb));
   endtask

   task automatic cycle(input bit e, input bit d, input bit use_v, input logic [W-1:0] v);
      en = e; dir = d;
      @(posedge clk);
      #1;
      model_step(e, d);
      set_drives(use_v, v);
      #1;
      check_all();
      $display("t=%0t en=%b dir=%b a=%h b=%h active=%b turning=%b cur_dir=%b cnt=%0d",
               $time, e, d, a_bus, b_bus, active, turning, cur_dir, xfer_cnt);
   endtask

   initial begin
      logic [W-1:0] xv;
      bit e, d;
      zval = {W{1'bz}};
      xv = 8'b1x0z_0101;
      rst = 1'b1; en = 1'b0; dir = 1'b0;
      a_oe = 1'b0; b_oe = 1'b0; a_drv = '0; b_drv = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Stays idle while en=0, then A->B with 5A, 01, 02, 03 streaming.
      cycle(0, 1, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(1, 0, 1, 8'h5A);
      cycle(1, 0, 1, 8'h01);
      cycle(1, 0, 1, 8'h02);
      cycle(1, 0, 1, 8'h03);
      repeat (10) cycle(1, 0, 0, '0);

      // Reverse with dir toggling during the turn; turn length must not change.
      cycle(1, 1, 0, '0);
      cycle(1, 0, 0, '0);
      cycle(1, 1, 0, '0);
      cycle(1, 1, 1, xv);
      repeat (4) cycle(1, 1, 0, '0);

      // Reverse back to A->B.
      cycle(1, 0, 0, '0);
      cycle(1, 0, 0, '0);
      cycle(1, 0, 0, '0);
      repeat (3) cycle(1, 0, 0, '0);

      // Asynchronous reset between edges while B is being driven.
      #2;
      rst = 1'b1;
      #1;
      chk("rst_bus_b",    32'(b_bus),    32'(zval));
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
      chk("rst_active",   32'(active),   32'd0);
      model_reset();
      set_drives(0, '0);
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // Disable from an active transfer returns to idle.
      repeat (3) cycle(1, 0, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(0, 1, 0, '0);

      e = 1'b1; d = 1'b0;
      for (int i = 0; i < 300; i++) begin
         e = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) d = ~d;
         cycle(e, d, 0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bidir_transceiver.md
BIDIR_TRANSCEIVER -- requirements
Module: bidir_transceiver

Interface
REQ-001 Parameter WIDTH, default 8, bit width of both bus sides (>=1).
REQ-002 Parameter TURN_CYC, default 2, dead cycles inserted on a direction reversal (>=1).
REQ-003 Parameter CNT_W, default 16, width of the transfer counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  1 = transceiver enabled; 0 = both sides released.
REQ-007 dir  input  1  requested direction: 0 = A->B, 1 = B->A.
REQ-008 a  inout  WIDTH  side A bus; driven only in state B2A with valid data, else high-Z.
REQ-009 b  inout  WIDTH  side B bus; driven only in state A2B with valid data, else high-Z.
REQ-010 cur_dir  output  1  direction of the current or last active state (0 = A->B).
REQ-011 active  output  1  1 while the destination side is being driven.
REQ-012 turning  output  1  1 while in state TURN.
REQ-013 xfer_cnt  output  CNT_W  count of cycles in which a destination side was driven.

Function
REQ-014 The block SHALL implement FSM states IDLE, A2B, B2A, TURN.
REQ-015 IDLE: a and b high-Z; en=1 -> A2B if dir=0, B2A if dir=1, at next edge; en=0 -> stay.
REQ-016 A2B: each edge, data_q <= a; drive flag set at the first edge after entry; b = data_q while flag set; a high-Z.
REQ-017 B2A: mirror of A2B with a and b swapped.
REQ-018 Latency: value on source at edge k SHALL appear on destination immediately after edge k (one-edge registered path); destination first driven after the second edge in the state.
REQ-019 A2B with en=1 and dir=1 (or B2A with dir=0) SHALL go to TURN; drive flag cleared at the same edge.
REQ-020 TURN: both sides high-Z for exactly TURN_CYC cycles; then enter direction given by dir sampled on the final TURN edge.
REQ-021 dir toggling during TURN SHALL NOT restart or shorten the turn count.
REQ-022 en=0 in any state SHALL move to IDLE at next edge, clearing drive flag and turn counter.
REQ-023 a and b SHALL never both be driven by the block in the same cycle.
REQ-024 active = drive flag; turning = (state==TURN); cur_dir updates on entry to A2B/B2A only.
REQ-025 xfer_cnt SHALL increment by 1 at each edge where active=1, and saturate at 2^CNT_W-1 (no wrap).
REQ-026 Captured source value SHALL be forwarded unmodified, including X/Z in simulation.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, a and b high-Z, active=0, turning=0, cur_dir=0, xfer_cnt=0, data_q=0, turn counter=0.
REQ-028 rst asserted mid-transfer or mid-turn SHALL release both buses in the same cycle, without waiting for a clock edge.
REQ-029 After rst deasserts, the first state transition SHALL occur at the first rising edge with en=1.

Verification
REQ-030 rst, then en=1 dir=0, a=8'h5A -> b=8'h5A after second edge, a high-Z, active=1, cur_dir=0.
REQ-031 A2B streaming a=8'h01,8'h02,8'h03 on successive edges -> b shows same sequence one edge later; xfer_cnt increments per cycle.
REQ-032 In A2B set dir=1 (TURN_CYC=2) -> b high-Z next edge, turning=1 for 2 cycles, then B2A; a driven with b's value after following edge; never a and b both driven.
REQ-033 During TURN toggle dir 1->0->1 -> turn lasts exactly 2 cycles, exits to B2A.
REQ-034 Assert rst mid-A2B between edges -> b high-Z and xfer_cnt=0 immediately.
REQ-035 CNT_W=3, hold A2B 10 active cycles -> xfer_cnt stops at 7.
